// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory arbiter: width defaults and FSM states.
// The CLEAR state exists only when DMEM_ARB_CLEAR_EN is defined.
package data_mem_pkg;

    localparam int unsigned NB_DATA_DEF = 32;
    localparam int unsigned NB_ADDR_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3
`ifdef DMEM_ARB_CLEAR_EN
        ,
        ST_CLEAR = 3'd4
`endif
    } arb_state_e;

endpackage : data_mem_pkg

// File: rtl/mem_addr_counter.sv
// Address counter for dump/clear walks: synchronous load-to-zero, increment
// enable, and a flag raised on the last address. Wraps to zero naturally.
module mem_addr_counter
    import data_mem_pkg::*;
#(
    parameter int unsigned NB_ADDR = NB_ADDR_DEF
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_load_zero,
    input  logic               i_inc,
    output logic [NB_ADDR-1:0] o_count,
    output logic               o_last
);

    logic [NB_ADDR-1:0] count_q;
    logic [NB_ADDR-1:0] count_d;

    // Next count: load has priority over increment.
    always_comb begin
        count_d = count_q;
        if (i_load_zero) begin
            count_d = '0;
        end else if (i_inc) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;
    assign o_last  = &count_q;

endmodule : mem_addr_counter

// File: rtl/data_mem_arbiter.sv
// Arbitrates a single-port RAM between the CPU pipeline (absolute priority)
// and a debug dump engine that walks every address. Optional compile-time
// macro DMEM_ARB_CLEAR_EN adds a zero-fill sequence (i_clear_start/o_clear_busy).
module data_mem_arbiter
    import data_mem_pkg::*;
#(
    parameter int unsigned NB_DATA = NB_DATA_DEF,
    parameter int unsigned NB_ADDR = NB_ADDR_DEF
) (
    input  logic               clk,
    input  logic               i_rst_n,
    // pipeline port
    input  logic               i_pipe_req,
    input  logic               i_pipe_we,
    input  logic [NB_ADDR-1:0] i_pipe_addr,
    input  logic [NB_DATA-1:0] i_pipe_wdata,
    output logic [NB_DATA-1:0] o_pipe_rdata,
    // debug dump port
    input  logic               i_dump_start,
    output logic               o_dump_busy,
    output logic               o_dump_valid,
    input  logic               i_dump_ready,
    output logic [NB_ADDR-1:0] o_dump_addr,
    output logic [NB_DATA-1:0] o_dump_data,
    output logic               o_dump_done,
`ifdef DMEM_ARB_CLEAR_EN
    input  logic               i_clear_start,
    output logic               o_clear_busy,
`endif
    // RAM port
    output logic               o_ram_we,
    output logic [NB_ADDR-1:0] o_ram_addr,
    output logic [NB_DATA-1:0] o_ram_wdata,
    input  logic [NB_DATA-1:0] i_ram_rdata
);

    arb_state_e         state_q, state_d;
    logic [NB_ADDR-1:0] dump_addr_q, dump_addr_d;
    logic [NB_DATA-1:0] dump_data_q, dump_data_d;
    logic               done_q, done_d;
    logic               cnt_load, cnt_inc, cnt_last;
    logic [NB_ADDR-1:0] cnt;

    mem_addr_counter #(
        .NB_ADDR (NB_ADDR)
    ) u_addr_cnt (
        .clk         (clk),
        .i_rst_n     (i_rst_n),
        .i_load_zero (cnt_load),
        .i_inc       (cnt_inc),
        .o_count     (cnt),
        .o_last      (cnt_last)
    );

    // Next-state, counter control and dump word capture.
    always_comb begin
        state_d     = state_q;
        dump_addr_d = dump_addr_q;
        dump_data_d = dump_data_q;
        done_d      = 1'b0;
        cnt_load    = 1'b0;
        cnt_inc     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_dump_start) begin
                    state_d  = ST_ISSUE;
                    cnt_load = 1'b1;
                end
`ifdef DMEM_ARB_CLEAR_EN
                else if (i_clear_start) begin
                    state_d  = ST_CLEAR;
                    cnt_load = 1'b1;
                end
`endif
            end
            ST_ISSUE: begin
                if (!i_pipe_req) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                dump_data_d = i_ram_rdata;
                dump_addr_d = cnt;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (i_dump_ready) begin
                    cnt_inc = 1'b1;
                    if (cnt_last) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
`ifdef DMEM_ARB_CLEAR_EN
            ST_CLEAR: begin
                if (!i_pipe_req) begin
                    cnt_inc = 1'b1;
                    if (cnt_last) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // State and dump output registers.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            dump_addr_q <= '0;
            dump_data_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dump_addr_q <= dump_addr_d;
            dump_data_q <= dump_data_d;
            done_q      <= done_d;
        end
    end

    // RAM port mux: pipeline first, then the engine's own slot.
    always_comb begin
        o_ram_we    = 1'b0;
        o_ram_addr  = i_pipe_addr;
        o_ram_wdata = i_pipe_wdata;
        if (i_pipe_req) begin
            o_ram_we = i_pipe_we;
        end else if (state_q == ST_ISSUE) begin
            o_ram_addr = cnt;
        end
`ifdef DMEM_ARB_CLEAR_EN
        else if (state_q == ST_CLEAR) begin
            o_ram_we    = 1'b1;
            o_ram_addr  = cnt;
            o_ram_wdata = '0;
        end
`endif
    end

    assign o_pipe_rdata = i_ram_rdata;
    assign o_dump_busy  = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_HOLD);
    assign o_dump_valid = (state_q == ST_HOLD);
    assign o_dump_addr  = dump_addr_q;
    assign o_dump_data  = dump_data_q;
    assign o_dump_done  = done_q;
`ifdef DMEM_ARB_CLEAR_EN
    assign o_clear_busy = (state_q == ST_CLEAR);
`endif

endmodule : data_mem_arbiter

// File: tb/tb_data_mem_arbiter.sv
// Testbench for data_mem_arbiter: synchronous RAM model, transaction-level
// reference model, per-cycle compare, directed and randomized scenarios.
module tb_data_mem_arbiter;

    localparam int N = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_req, pipe_we;
    logic [7:0]  pipe_addr;
    logic [31:0] pipe_wdata, pipe_rdata;
    logic        dump_start, dump_busy, dump_valid, dump_ready, dump_done;
    logic [7:0]  dump_addr;
    logic [31:0] dump_data;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
`ifdef DMEM_ARB_CLEAR_EN
    logic        clear_start, clear_busy;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    int busy_cnt;
    int wa_q[$];
    logic [31:0] wd_q[$];

    always #5 clk = ~clk;

    data_mem_arbiter #(
        .NB_DATA (32),
        .NB_ADDR (8)
    ) dut (
        .clk          (clk),
        .i_rst_n      (rst_n),
        .i_pipe_req   (pipe_req),
        .i_pipe_we    (pipe_we),
        .i_pipe_addr  (pipe_addr),
        .i_pipe_wdata (pipe_wdata),
        .o_pipe_rdata (pipe_rdata),
        .i_dump_start (dump_start),
        .o_dump_busy  (dump_busy),
        .o_dump_valid (dump_valid),
        .i_dump_ready (dump_ready),
        .o_dump_addr  (dump_addr),
        .o_dump_data  (dump_data),
        .o_dump_done  (dump_done),
`ifdef DMEM_ARB_CLEAR_EN
        .i_clear_start(clear_start),
        .o_clear_busy (clear_busy),
`endif
        .o_ram_we     (ram_we),
        .o_ram_addr   (ram_addr),
        .o_ram_wdata  (ram_wdata),
        .i_ram_rdata  (ram_rdata)
    );

    // External synchronous RAM, read-before-write, one cycle read latency.
    logic [31:0] mem [N];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // Reference model: memory image plus an abstract walk over all addresses.
    typedef enum int {M_IDLE, M_DUMP, M_CLEAR} mode_e;
    mode_e       m_mode = M_IDLE;
    int          m_addr = 0;
    int          m_step = 0;   // 0 = needs a free RAM slot, 1 = latency, 2 = word presented
    logic [31:0] m_rd;
    int          m_wa   = 0;
    logic [31:0] m_wd   = '0;
    bit          m_done = 1'b0;
    logic [31:0] ref_mem [N];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= M_IDLE;
            m_addr <= 0;
            m_step <= 0;
            m_wa   <= 0;
            m_wd   <= '0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (pipe_req && pipe_we) ref_mem[pipe_addr] <= pipe_wdata;
            case (m_mode)
                M_IDLE: begin
                    if (dump_start) begin
                        m_mode <= M_DUMP; m_addr <= 0; m_step <= 0;
                    end
`ifdef DMEM_ARB_CLEAR_EN
                    else if (clear_start) begin
                        m_mode <= M_CLEAR; m_addr <= 0;
                    end
`endif
                end
                M_DUMP: begin
                    if (m_step == 0) begin
                        if (!pipe_req) begin
                            m_rd <= ref_mem[m_addr]; m_step <= 1;
                        end
                    end else if (m_step == 1) begin
                        m_wd <= m_rd; m_wa <= m_addr; m_step <= 2;
                    end else if (dump_ready) begin
                        if (m_addr == N - 1) begin
                            m_mode <= M_IDLE; m_done <= 1'b1;
                        end else begin
                            m_addr <= m_addr + 1; m_step <= 0;
                        end
                    end
                end
                default: begin
                    if (!pipe_req) begin
                        ref_mem[m_addr] <= '0;
                        if (m_addr == N - 1) begin
                            m_mode <= M_IDLE; m_done <= 1'b1;
                        end
                        m_addr <= (m_addr + 1) % N;
                    end
                end
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin : cmp
        logic        e_we;
        logic [7:0]  e_addr;
        logic [31:0] e_wd;
        if (chk_en) begin
            e_we = 1'b0; e_addr = pipe_addr; e_wd = pipe_wdata;
            if (pipe_req) begin
                e_we = pipe_we;
            end else if (m_mode == M_DUMP && m_step == 0) begin
                e_addr = m_addr[7:0];
            end else if (m_mode == M_CLEAR) begin
                e_we = 1'b1; e_addr = m_addr[7:0]; e_wd = '0;
            end
            chk("pipe_rdata", pipe_rdata, ram_rdata);
            chk("ram_we", {31'd0, ram_we}, {31'd0, e_we});
            chk("ram_addr", {24'd0, ram_addr}, {24'd0, e_addr});
            if (e_we) chk("ram_wdata", ram_wdata, e_wd);
            chk("dump_busy", {31'd0, dump_busy}, {31'd0, m_mode == M_DUMP});
            chk("dump_valid", {31'd0, dump_valid}, {31'd0, m_mode == M_DUMP && m_step == 2});
            chk("dump_done", {31'd0, dump_done}, {31'd0, m_done});
            chk("dump_addr", {24'd0, dump_addr}, m_wa);
            chk("dump_data", dump_data, m_wd);
`ifdef DMEM_ARB_CLEAR_EN
            chk("clear_busy", {31'd0, clear_busy}, {31'd0, m_mode == M_CLEAR});
`endif
        end
        if (dump_busy) busy_cnt++;
        if (dump_valid && dump_ready) begin
            wa_q.push_back(int'(dump_addr));
            wd_q.push_back(dump_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int max, input string nm);
        int c;
        for (c = 0; c < max; c++) begin
            tick();
            if (dump_done) break;
        end
        chk(nm, c < max, 1);
    endtask

    task automatic wait_word(input int a, input string nm);
        int c;
        for (c = 0; c < 400; c++) begin
            if (dump_valid && dump_addr == a[7:0]) break;
            tick();
        end
        chk(nm, c < 400, 1);
    endtask

    task automatic start_dump();
        wa_q.delete(); wd_q.delete();
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
    endtask

    initial begin
        logic [7:0]  ha;
        logic [31:0] hd;
        rst_n = 1'b0; pipe_req = 1'b0; pipe_we = 1'b0; pipe_addr = '0; pipe_wdata = '0;
        dump_start = 1'b0; dump_ready = 1'b0;
`ifdef DMEM_ARB_CLEAR_EN
        clear_start = 1'b0;
`endif
        tick();
        chk_en = 1'b1;
        tick(); tick();
        chk("rst_busy", {31'd0, dump_busy}, 0);
        chk("rst_valid", {31'd0, dump_valid}, 0);
        chk("rst_done", {31'd0, dump_done}, 0);
        chk("rst_daddr", {24'd0, dump_addr}, 0);
        chk("rst_ddata", dump_data, 0);
        rst_n = 1'b1;
        tick();

        // Preload RAM[i] = i + 100 through the pipeline port.
        for (int i = 0; i < N; i++) begin
            pipe_req = 1'b1; pipe_we = 1'b1; pipe_addr = i[7:0]; pipe_wdata = i + 100;
            tick();
        end
        pipe_req = 1'b0; pipe_we = 1'b0;
        tick();
        chk("no_auto_start", {31'd0, dump_busy}, 0);

        // Full dump, consumer always ready, pipe idle.
        dump_ready = 1'b1;
        busy_cnt = 0;
        start_dump();
        chk("busy_after_start", {31'd0, dump_busy}, 1);
        wait_done(2000, "dump1_timeout");
        chk("dump1_busy_off", {31'd0, dump_busy}, 0);
        tick();
        chk("dump1_cycles", busy_cnt, 768);
        chk("dump1_count", wa_q.size(), 256);
        if (wa_q.size() == N) begin
            chk("dump1_first_addr", wa_q[0], 0);
            chk("dump1_first_data", wd_q[0], 100);
            chk("dump1_last_addr", wa_q[N-1], 255);
            for (int i = 0; i < N; i++) begin
                chk("dump1_addr", wa_q[i], i);
                chk("dump1_data", wd_q[i], i + 100);
            end
        end

        // Stall in ISSUE, pipeline store to 5, ready low in HOLD, reset at 40.
        start_dump();
        wait_word(2, "w2_timeout");
        tick();
        for (int k = 0; k < 10; k++) begin
            pipe_req = 1'b1;
            pipe_we = (k == 9);
            pipe_addr = (k == 9) ? 8'd5 : 8'($urandom_range(0, 255));
            pipe_wdata = 32'hDEAD;
            #1;
            chk("stall_ram_addr", {24'd0, ram_addr}, {24'd0, pipe_addr});
            chk("stall_ram_we", {31'd0, ram_we}, {31'd0, pipe_we});
            chk("stall_no_valid", {31'd0, dump_valid}, 0);
            tick();
        end
        pipe_req = 1'b0; pipe_we = 1'b0;
        wait_word(10, "w10_timeout");
        dump_ready = 1'b0;
        ha = dump_addr; hd = dump_data;
        chk("hold_data_lit", hd, 110);
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("hold_valid", {31'd0, dump_valid}, 1);
            chk("hold_addr", {24'd0, dump_addr}, {24'd0, ha});
            chk("hold_data", dump_data, hd);
            chk("hold_no_write", {31'd0, ram_we}, 0);
        end
        dump_ready = 1'b1;
        wait_word(40, "w40_timeout");
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, dump_busy}, 0);
        chk("mid_rst_valid", {31'd0, dump_valid}, 0);
        chk("mid_rst_done", {31'd0, dump_done}, 0);
        chk("mid_rst_daddr", {24'd0, dump_addr}, 0);
        chk("mid_rst_ddata", dump_data, 0);
        chk("mid_rst_we", {31'd0, ram_we}, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("post_rst_idle", {31'd0, dump_busy}, 0);
        chk("dump2_count", wa_q.size(), 40);
        if (wa_q.size() == 40) begin
            for (int i = 0; i < 40; i++) begin
                chk("dump2_addr", wa_q[i], i);
                chk("dump2_data", wd_q[i], (i == 5) ? 32'hDEAD : 32'(i + 100));
            end
        end

        // Randomized traffic: pipe accesses, consumer back-pressure, stray starts.
        start_dump();
        begin : rnd
            int c;
            for (c = 0; c < 6000; c++) begin
                tick();
                if (dump_done) break;
                pipe_req   = ($urandom_range(0, 2) == 0);
                pipe_we    = $urandom_range(0, 1) == 1;
                pipe_addr  = 8'($urandom_range(0, 255));
                pipe_wdata = $urandom;
                dump_ready = ($urandom_range(0, 3) != 0);
                dump_start = ($urandom_range(0, 7) == 0);
`ifdef DMEM_ARB_CLEAR_EN
                clear_start = ($urandom_range(0, 7) == 0);
`endif
            end
            chk("rnd_timeout", c < 6000, 1);
        end
        pipe_req = 1'b0; pipe_we = 1'b0; dump_start = 1'b0; dump_ready = 1'b1;
`ifdef DMEM_ARB_CLEAR_EN
        clear_start = 1'b0;
`endif
        tick();
        chk("rnd_count", wa_q.size(), 256);
        if (wa_q.size() == N) begin
            chk("rnd_restart_addr0", wa_q[0], 0);
            for (int i = 0; i < N; i++) chk("rnd_addr", wa_q[i], i);
        end

`ifdef DMEM_ARB_CLEAR_EN
        // Clear with pipeline reads interleaved, then dump all zeros.
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        chk("clr_busy", {31'd0, clear_busy}, 1);
        chk("clr_not_dump", {31'd0, dump_busy}, 0);
        begin : clr
            int c;
            for (c = 0; c < 2000; c++) begin
                tick();
                if (dump_done) break;
                pipe_req = ($urandom_range(0, 2) == 0);
                pipe_we = 1'b0;
                pipe_addr = 8'($urandom_range(0, 255));
            end
            chk("clr_timeout", c < 2000, 1);
        end
        pipe_req = 1'b0;
        tick();
        start_dump();
        wait_done(2000, "dump_zero_timeout");
        tick();
        chk("dump_zero_count", wa_q.size(), 256);
        for (int i = 0; i < wa_q.size(); i++) chk("dump_zero_data", wd_q[i], 0);

        // Simultaneous start pulses: dump wins, RAM[7] survives.
        pipe_req = 1'b1; pipe_we = 1'b1; pipe_addr = 8'd7; pipe_wdata = 32'h77;
        tick();
        pipe_req = 1'b0; pipe_we = 1'b0;
        clear_start = 1'b1;
        start_dump();
        clear_start = 1'b0;
        chk("both_dump_busy", {31'd0, dump_busy}, 1);
        chk("both_no_clear", {31'd0, clear_busy}, 0);
        wait_done(2000, "both_timeout");
        tick();
        chk("both_count", wa_q.size(), 256);
        if (wa_q.size() == N) chk("both_word7", wd_q[7], 32'h77);
`endif

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_data_mem_arbiter
